led_fader: RTL and testbench
============================

Name: led_fader

Overview:
- Downstream of the switch/button/LED peripheral: consumes its registered on/off LED vector and drives the physical LED pins.
- Each LED output ramps its brightness up or down, instead of switching hard, using per-LED brightness registers and a shared PWM counter.
- A fade bypass allows instant on/off for bring-up.
- Sits between the peripheral's LED output and the board pins.

Parameters:
- NLEDS, 8, number of LED channels.
- BW, 8, brightness/PWM width in bits; full scale FS = 2^BW-1.
- DIVW, 16, fade prescaler width; one fade tick every 2^DIVW clocks.
- RISE, 4, brightness increment per tick while target is on (1..FS).
- FALL, 2, brightness decrement per tick while target is off (1..FS).

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_led  input  NLEDS  target on/off state per LED (from peripheral o_led).
- i_fade_en  input  1  1 = ramp brightness; 0 = brightness snaps to target.
- o_led  output  NLEDS  PWM drive to LED pins.
- o_busy  output  1  high while any brightness register differs from its target level (0 or FS).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high, ports i_clk and i_reset.
- Reset values: prescaler=0, pwm counter=0, all brightness=0, o_led=0, o_busy=0.
- Reset asserted mid-ramp clears everything on assertion, without waiting for a clock. After release, ramps restart from 0.
- Prescaler:
  - DIVW-bit free-running counter.
  - tick=1 for exactly one cycle when the counter equals 2^DIVW-1, then wraps to 0.
- Brightness update, per LED k, registered:
  - i_fade_en=0: bright[k] <= i_led[k] ? FS : 0 on every clock, independent of tick.
  - i_fade_en=1 and tick=1, target on: bright[k] <= min(bright[k]+RISE, FS). Compute the sum at BW+1 bits so it never wraps.
  - i_fade_en=1 and tick=1, target off: bright[k] <= max(bright[k]-FALL, 0). Compute at BW+1 bits signed or with compare-first; no underflow wrap.
  - i_fade_en=1 and tick=0: hold.
- Target change mid-ramp: direction reverses at the next tick from the current value. No restart, no jump.
- PWM:
  - BW-bit free-running counter pwm, 0..FS, wraps.
  - o_led[k] <= (bright[k]==FS) ? 1 : (pwm < bright[k]). Registered, one clock after the compare.
  - bright=0 gives a constant 0; bright=FS gives a constant 1 (no glitch at wrap).
- o_busy: registered; equals OR over k of (bright[k] != (i_led[k] ? FS : 0)), evaluated on the current-cycle values of bright and i_led.
- Latency:
  - i_led change with fade disabled: bright updates at clock+1, o_led reflects it at clock+2.
  - With fade enabled: first step at the next tick.
- i_fade_en toggled 1->0 mid-ramp: snap on the next clock. 0->1: ramping resumes from the current (saturated) level.
- All channels share the prescaler and PWM counters; channels update in the same cycle.

Test Plan:
1. NLEDS=2, BW=4, DIVW=2, RISE=4, FALL=2, fade_en=1. Reset, then i_led=2'b01 → bright[0] steps 0,4,8,12,15 on ticks every 4 clocks; bright[1] stays 0. o_busy=1 until bright[0]=15, then 0. o_led[0] is constantly 1 once bright[0]=15.
2. Same config, bright[0]=15, i_led=0 → bright[0] steps 13,11,9,7,5,3,1,0 (saturating, no wrap to 15). o_led[0] constant 0 at the end.
3. bright[0]=8, pwm sweeping 0..15 → o_led[0] high for exactly 8 of every 16 clocks, delayed one clock after the pwm compare.
4. fade_en=0, i_led toggles 0→1 at cycle t → bright=15 at t+1, o_led=1 at t+2; toggling back gives o_led=0 at t+2 likewise.
5. Mid-ramp reversal: bright[0]=8 rising, i_led→0 before the next tick → next tick gives 6, never 12.
6. Assert i_reset asynchronously between clock edges while bright[0]=12 → o_led, o_busy and all brightness values read 0 immediately. After release with i_led=1, ramp restarts at 4.

Source files
------------

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// Module   : led_fader
// Brief    : Per-channel LED brightness ramping with a shared fade prescaler
//            and a shared PWM counter. A fade bypass snaps brightness
//            straight to the on/off target.
// Revision : 1.0 - initial release
// ============================================================================
module led_fader #(
    parameter int NLEDS = 8,
    parameter int BW    = 8,
    parameter int DIVW  = 16,
    parameter int RISE  = 4,
    parameter int FALL  = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NLEDS-1:0] i_led,
    input  logic             i_fade_en,
    output logic [NLEDS-1:0] o_led,
    output logic             o_busy
);

    localparam logic [BW-1:0] c_fs   = {BW{1'b1}};
    localparam logic [BW:0]   c_rise = (BW+1)'(RISE);
    localparam logic [BW-1:0] c_fall = BW'(FALL);

    logic [DIVW-1:0]            r_div;
    logic [BW-1:0]              r_pwm;
    logic                       w_tick;
    logic [NLEDS-1:0][BW-1:0]   r_bright;
    logic [NLEDS-1:0][BW-1:0]   w_next;
    logic [NLEDS-1:0][BW-1:0]   w_target;
    logic [NLEDS-1:0][BW:0]     w_rise_sum;
    logic [NLEDS-1:0]           w_diff;

    // One fade step per full wrap of the prescaler.
    assign w_tick = &r_div;

    // Free-running prescaler and PWM counters, shared by all channels.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div <= '0;
            r_pwm <= '0;
        end else begin
            r_div <= r_div + 1'b1;
            r_pwm <= r_pwm + 1'b1;
        end
    end

    // Next brightness per channel: snap in bypass, otherwise saturating step on tick.
    always_comb begin
        for (int k = 0; k < NLEDS; k++) begin
            w_target[k]   = i_led[k] ? c_fs : '0;
            // One extra bit so the rising sum can be clamped instead of wrapping.
            w_rise_sum[k] = {1'b0, r_bright[k]} + c_rise;
            w_diff[k]     = (r_bright[k] != w_target[k]);
            if (!i_fade_en) begin
                w_next[k] = w_target[k];
            end else if (!w_tick) begin
                w_next[k] = r_bright[k];
            end else if (i_led[k]) begin
                w_next[k] = (w_rise_sum[k] > {1'b0, c_fs}) ? c_fs : w_rise_sum[k][BW-1:0];
            end else begin
                // Compare first so the falling ramp floors at zero.
                w_next[k] = (r_bright[k] > c_fall) ? (r_bright[k] - c_fall) : '0;
            end
        end
    end

    // Brightness registers, PWM compare outputs and busy flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bright <= '0;
            o_led    <= '0;
            o_busy   <= 1'b0;
        end else begin
            r_bright <= w_next;
            o_busy   <= |w_diff;
            for (int k = 0; k < NLEDS; k++) begin
                // Full scale is forced high so the output never dips at PWM wrap.
                o_led[k] <= (r_bright[k] == c_fs) || (r_pwm < r_bright[k]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_fader
// Brief    : Directed self-checking bench for led_fader (NLEDS=2, BW=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_fader;

    logic       clk = 1'b0;
    logic       rst;
    logic       fade;
    logic [1:0] led;
    logic [1:0] o_led;
    logic       busy;
    logic [1:0] o_led2;
    logic       busy2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    logic [3:0] sb_q[$];

    always #5 clk = ~clk;

    led_fader #(.NLEDS(2), .BW(4), .DIVW(2), .RISE(4), .FALL(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_led(led), .i_fade_en(fade),
        .o_led(o_led), .o_busy(busy)
    );

    // Slow-tick instance so a mid-scale brightness holds long enough to see full PWM periods.
    led_fader #(.NLEDS(2), .BW(4), .DIVW(8), .RISE(4), .FALL(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_led(led), .i_fade_en(fade),
        .o_led(o_led2), .o_busy(busy2)
    );

    // Clock edges since reset release; PWM value after edge n is n mod 16.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_bright_change(input int maxc, output int ncyc, output logic [3:0] val);
        logic [3:0] prev;
        prev = dut.r_bright[0];
        ncyc = 0;
        while (ncyc < maxc) begin
            @(negedge clk);
            ncyc++;
            if (dut.r_bright[0] !== prev) break;
        end
        val = dut.r_bright[0];
        if (val === prev) begin
            n_cmp++;
            n_err++;
            $error("FAIL step_timeout: observed=no change in %0d clocks expected=change", maxc);
        end
    endtask

    // Pops each expected brightness as the DUT produces its next step.
    task automatic expect_steps(input string tag, input bit check_first);
        int         i;
        int         n;
        logic [3:0] v;
        logic [3:0] e;
        i = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            wait_bright_change(8, n, v);
            check({tag, "_value"}, v, e);
            if (i > 0 || check_first) check({tag, "_interval"}, n, 4);
            i++;
        end
    endtask

    task automatic count_high(input int bitsel, input int ncyc, output int hits);
        hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (o_led[bitsel]) hits++;
        end
    endtask

    initial begin
        int         hits;
        int         guard;
        logic [15:0] pat_obs;
        logic [15:0] pat_exp;

        rst  = 1'b1;
        led  = 2'b00;
        fade = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset_bright0", dut.r_bright[0], 0);
        check("reset_bright1", dut.r_bright[1], 0);
        check("reset_o_led",   o_led, 0);
        check("reset_busy",    busy, 0);

        // PWM duty at brightness 8 on the slow-tick instance
        led = 2'b01;
        rst = 1'b0;
        guard = 0;
        while (dut2.r_bright[0] !== 4'd8 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check("pwm_reach8_cycle", cyc, 512);
        pat_obs = '0;
        pat_exp = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pat_obs[i] = o_led2[0];
            pat_exp[i] = (((cyc - 1) % 16) < 8);
        end
        check("pwm_pattern", pat_obs, pat_exp);
        check("pwm_duty", $countones(pat_obs), 8);

        // Ramp up from reset
        rst = 1'b1;
        led = 2'b00;
        @(negedge clk);
        led = 2'b01;
        rst = 1'b0;
        sb_q.push_back(4'd4);
        sb_q.push_back(4'd8);
        sb_q.push_back(4'd12);
        sb_q.push_back(4'd15);
        expect_steps("rise", 1'b1);
        check("rise_busy_before_full", busy, 1);
        @(negedge clk);
        check("rise_busy_at_full", busy, 0);
        count_high(0, 32, hits);
        check("rise_full_led0_const1", hits, 32);
        check("rise_bright1_zero", dut.r_bright[1], 0);
        check("rise_full_bright_held", dut.r_bright[0], 15);

        // Ramp down, saturating at zero
        led = 2'b00;
        foreach (sb_q[i]) sb_q.delete(i);
        sb_q.push_back(4'd13);
        sb_q.push_back(4'd11);
        sb_q.push_back(4'd9);
        sb_q.push_back(4'd7);
        sb_q.push_back(4'd5);
        sb_q.push_back(4'd3);
        sb_q.push_back(4'd1);
        sb_q.push_back(4'd0);
        expect_steps("fall", 1'b0);
        @(negedge clk);
        check("fall_busy_at_zero", busy, 0);
        repeat (12) @(negedge clk);
        check("fall_no_wrap", dut.r_bright[0], 0);
        count_high(0, 32, hits);
        check("fall_led0_const0", hits, 0);

        // Fade bypass: snap and two-clock output latency
        fade = 1'b0;
        @(negedge clk);
        led = 2'b01;
        @(negedge clk);
        check("snap_on_bright_t1", dut.r_bright[0], 15);
        check("snap_on_led_t1",    o_led[0], 0);
        check("snap_on_busy_t1",   busy, 1);
        @(negedge clk);
        check("snap_on_led_t2",    o_led[0], 1);
        check("snap_on_busy_t2",   busy, 0);
        led = 2'b00;
        @(negedge clk);
        check("snap_off_bright_t1", dut.r_bright[0], 0);
        check("snap_off_led_t1",    o_led[0], 1);
        @(negedge clk);
        check("snap_off_led_t2",    o_led[0], 0);

        // Mid-ramp reversal from 8
        fade = 1'b1;
        led  = 2'b01;
        guard = 0;
        while (dut.r_bright[0] !== 4'd8 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rev_reach8", dut.r_bright[0], 8);
        led = 2'b00;
        sb_q.push_back(4'd6);
        expect_steps("reverse", 1'b1);

        // Asynchronous reset mid-ramp at brightness 12
        fade = 1'b0;
        @(negedge clk);
        check("pre_reset_snap0", dut.r_bright[0], 0);
        fade = 1'b1;
        led  = 2'b01;
        guard = 0;
        while (dut.r_bright[0] !== 4'd12 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("pre_reset_bright12", dut.r_bright[0], 12);
        check("pre_reset_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_bright0", dut.r_bright[0], 0);
        check("async_reset_bright1", dut.r_bright[1], 0);
        check("async_reset_o_led",   o_led, 0);
        check("async_reset_busy",    busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(4'd4);
        expect_steps("post_reset", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
